// File: rtl/sm2201_isa_cycle_controller.sv
// ISA-side front end of the SM2201 board: address latch and decode, IOR/IOW
// synchronisation, one-cycle register strobes, CHRDY wait-state control and read-back.
module sm2201_isa_cycle_controller #(
    parameter logic [9:0]  BASE_ADDR   = 10'h110,
    parameter int unsigned REG_AW      = 2,
    parameter int unsigned WAIT_CYCLES = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              isa_clk,
    input  logic              isa_reset_n,
    input  logic [9:0]        isa_addr,
    input  logic              isa_ale,
    input  logic              isa_aen,
    input  logic              isa_ior,
    input  logic              isa_iow,
    input  logic [7:0]        isa_data_in,
    output logic [7:0]        isa_data_out,
    output logic              isa_data_oe,
    output logic              isa_chrdy,
    output logic [REG_AW-1:0] reg_addr,
    output logic              reg_wr_stb,
    output logic [7:0]        reg_wr_data,
    output logic              reg_rd_stb,
    input  logic [7:0]        reg_rd_data,
    input  logic              reg_ack,
    output logic              cycle_timeout
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT_ACK,
        HOLD
    } state_t;

    state_t                  state_q;
    logic [9:0]              addr_q;
    logic [SYNC_STAGES-1:0]  ior_sync_q;
    logic [SYNC_STAGES-1:0]  iow_sync_q;
    logic                    ior_prev_q;
    logic                    iow_prev_q;
    logic [CNT_W-1:0]        wait_cnt_q;
    logic [CNT_W-1:0]        wait_cnt_d;
    logic                    rd_cycle_q;
    logic                    chrdy_q;
    logic                    oe_q;
    logic [7:0]              rd_q;
    logic                    rd_stb_q;
    logic                    wr_stb_q;
    logic                    timeout_q;
    logic [REG_AW-1:0]       reg_addr_q;
    logic [7:0]              wr_data_q;

    logic ior_s;
    logic iow_s;
    logic start_rd;
    logic start_wr;
    logic hit;
    logic wait_expired;

    always_ff @(posedge isa_clk or negedge isa_reset_n) begin
        if (!isa_reset_n) begin
            addr_q <= '0;
        end else if (isa_ale) begin
            addr_q <= isa_addr;
        end
    end

    always_ff @(posedge isa_clk or negedge isa_reset_n) begin
        if (!isa_reset_n) begin
            ior_sync_q <= '1;
            iow_sync_q <= '1;
            ior_prev_q <= 1'b1;
            iow_prev_q <= 1'b1;
        end else begin
            ior_sync_q <= {ior_sync_q[SYNC_STAGES-2:0], isa_ior};
            iow_sync_q <= {iow_sync_q[SYNC_STAGES-2:0], isa_iow};
            ior_prev_q <= ior_s;
            iow_prev_q <= iow_s;
        end
    end

    assign ior_s = ior_sync_q[SYNC_STAGES-1];
    assign iow_s = iow_sync_q[SYNC_STAGES-1];

    // A start needs the other strobe idle-high; simultaneous or overlapping falls are ignored.
    assign start_rd = ior_prev_q && !ior_s && iow_s;
    assign start_wr = iow_prev_q && !iow_s && ior_s;

    assign hit = (addr_q[9:REG_AW] == BASE_ADDR[9:REG_AW]) && !isa_aen;

    assign wait_cnt_d   = wait_cnt_q + CNT_W'(1);
    assign wait_expired = (wait_cnt_d == CNT_W'(WAIT_CYCLES - 1));

    always_ff @(posedge isa_clk or negedge isa_reset_n) begin
        if (!isa_reset_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            rd_cycle_q <= 1'b0;
            chrdy_q    <= 1'b1;
            oe_q       <= 1'b0;
            rd_q       <= '0;
            rd_stb_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            timeout_q  <= 1'b0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
        end else begin
            rd_stb_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    chrdy_q <= 1'b1;
                    oe_q    <= 1'b0;
                    if ((start_rd || start_wr) && hit) begin
                        state_q    <= STROBE;
                        reg_addr_q <= addr_q[REG_AW-1:0];
                        rd_cycle_q <= start_rd;
                        rd_stb_q   <= start_rd;
                        wr_stb_q   <= start_wr;
                        chrdy_q    <= 1'b0;
                        if (start_wr) begin
                            wr_data_q <= isa_data_in;
                        end
                    end
                end
                STROBE: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    wait_cnt_q <= wait_cnt_d;
                    if (reg_ack) begin
                        state_q <= HOLD;
                        chrdy_q <= 1'b1;
                        if (rd_cycle_q) begin
                            rd_q <= reg_rd_data;
                            oe_q <= !ior_s;
                        end
                    end else if (wait_expired) begin
                        // Forced release: the bus gets all-ones instead of stale data.
                        state_q   <= HOLD;
                        chrdy_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        rd_q      <= 8'hFF;
                        oe_q      <= rd_cycle_q && !ior_s;
                    end
                end
                HOLD: begin
                    chrdy_q <= 1'b1;
                    if (ior_s && iow_s) begin
                        state_q <= IDLE;
                        oe_q    <= 1'b0;
                    end else begin
                        oe_q <= rd_cycle_q && !ior_s;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign isa_data_out  = rd_q;
    assign isa_data_oe   = oe_q;
    assign isa_chrdy     = chrdy_q;
    assign reg_addr      = reg_addr_q;
    assign reg_wr_stb    = wr_stb_q;
    assign reg_wr_data   = wr_data_q;
    assign reg_rd_stb    = rd_stb_q;
    assign cycle_timeout = timeout_q;

endmodule

// File: tb/tb_sm2201_isa_cycle_controller.sv
// Directed bench for sm2201_isa_cycle_controller: a per-transaction timeline model
// fills expected waveforms which one negedge process compares against the DUT.
module tb_sm2201_isa_cycle_controller;

    localparam int SYNC = 2;
    localparam int W    = 8;
    localparam int BASE = 'h110;
    localparam int N    = 1024;

    logic       clk = 1'b0;
    logic       isa_reset_n;
    logic [9:0] isa_addr;
    logic       isa_ale;
    logic       isa_aen;
    logic       isa_ior;
    logic       isa_iow;
    logic [7:0] isa_data_in;
    logic [7:0] isa_data_out;
    logic       isa_data_oe;
    logic       isa_chrdy;
    logic [1:0] reg_addr;
    logic       reg_wr_stb;
    logic [7:0] reg_wr_data;
    logic       reg_rd_stb;
    logic [7:0] reg_rd_data;
    logic       reg_ack;
    logic       cycle_timeout;

    always #5 clk = ~clk;

    sm2201_isa_cycle_controller #(
        .BASE_ADDR  (10'h110),
        .REG_AW     (2),
        .WAIT_CYCLES(W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .isa_clk      (clk),
        .isa_reset_n  (isa_reset_n),
        .isa_addr     (isa_addr),
        .isa_ale      (isa_ale),
        .isa_aen      (isa_aen),
        .isa_ior      (isa_ior),
        .isa_iow      (isa_iow),
        .isa_data_in  (isa_data_in),
        .isa_data_out (isa_data_out),
        .isa_data_oe  (isa_data_oe),
        .isa_chrdy    (isa_chrdy),
        .reg_addr     (reg_addr),
        .reg_wr_stb   (reg_wr_stb),
        .reg_wr_data  (reg_wr_data),
        .reg_rd_stb   (reg_rd_stb),
        .reg_rd_data  (reg_rd_data),
        .reg_ack      (reg_ack),
        .cycle_timeout(cycle_timeout)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected waveforms, indexed by the number of rising edges seen so far.
    bit         e_chrdy[N];
    bit         e_oe[N];
    bit         e_rs[N];
    bit         e_ws[N];
    bit         e_to[N];
    logic [1:0] e_addr[N];
    logic [7:0] e_wd[N];
    logic [7:0] e_dout[N];

    function automatic void fill_idle(input int from);
        for (int k = from; k < N; k++) begin
            e_chrdy[k] = 1'b1;
            e_oe[k]    = 1'b0;
            e_rs[k]    = 1'b0;
            e_ws[k]    = 1'b0;
            e_to[k]    = 1'b0;
            e_addr[k]  = '0;
            e_wd[k]    = '0;
            e_dout[k]  = '0;
        end
    endfunction

    int         mon_low, mon_rs, mon_ws, mon_to, mon_oe, mon_first, last_e;
    logic [7:0] mon_sd;

    task automatic clr_mon();
        mon_low = 0; mon_rs = 0; mon_ws = 0; mon_to = 0; mon_oe = 0;
        mon_first = -1; mon_sd = '0;
    endtask

    always @(negedge clk) begin
        int k;
        k = cyc;
        if (k < N) begin
            chk("chrdy", isa_chrdy, e_chrdy[k]);
            chk("oe", isa_data_oe, e_oe[k]);
            chk("rd_stb", reg_rd_stb, e_rs[k]);
            chk("wr_stb", reg_wr_stb, e_ws[k]);
            chk("timeout", cycle_timeout, e_to[k]);
            chk("reg_addr", reg_addr, e_addr[k]);
            chk("wr_data", reg_wr_data, e_wd[k]);
            if (e_oe[k]) chk("sd", isa_data_out, e_dout[k]);
            if (!isa_reset_n) chk("sd_rst", isa_data_out, 8'h00);
        end
        if (!isa_chrdy) mon_low++;
        if (reg_rd_stb) mon_rs++;
        if (reg_wr_stb) mon_ws++;
        if (cycle_timeout) mon_to++;
        if (isa_data_oe) begin
            mon_oe++;
            mon_sd = isa_data_out;
        end
        if ((reg_rd_stb || reg_wr_stb) && mon_first < 0) mon_first = k;
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus cycle: strobe low for low_len clocks; ack_d clocks after the register
    // strobe the ack is pulsed (0 = never). rst_at > 0 pulls reset that many clocks
    // after the strobe.
    task automatic do_cycle(input bit wr, input logic [9:0] a, input bit aen,
                            input logic [7:0] wd, input int ack_d, input logic [7:0] rd,
                            input int low_len, input int rst_at);
        int e, S, H, R, tend;
        bit hit, tmo;
        isa_addr = a;
        isa_ale  = 1'b1;
        wait_edges(1);
        isa_ale     = 1'b0;
        isa_addr    = a ^ 10'h3FF;
        isa_aen     = aen;
        isa_data_in = wd;
        reg_rd_data = rd;
        clr_mon();
        e = cyc;
        last_e = e;
        hit = (int'(a) >= BASE) && (int'(a) < BASE + 4) && !aen;
        S   = e + SYNC + 1;
        R   = e + low_len;
        tmo = !(ack_d >= 1 && ack_d <= W - 1);
        H   = tmo ? S + W : S + ack_d + 1;
        if (hit) begin
            for (int k = S; k < H; k++) e_chrdy[k] = 1'b0;
            if (wr) e_ws[S] = 1'b1;
            else    e_rs[S] = 1'b1;
            if (tmo) e_to[H] = 1'b1;
            for (int k = S; k < N; k++) begin
                e_addr[k] = 2'(int'(a) - BASE);
                if (wr) e_wd[k] = wd;
            end
            if (!wr) begin
                for (int k = H; k <= R + SYNC; k++) begin
                    e_oe[k]   = 1'b1;
                    e_dout[k] = tmo ? 8'hFF : rd;
                end
            end
            tend = ((H > R + SYNC) ? H : R + SYNC) + 3;
        end else begin
            tend = R + SYNC + 3;
        end
        for (int t = e; t < tend; t++) begin
            if (wr) isa_iow = (t >= R);
            else    isa_ior = (t >= R);
            reg_ack = hit && !tmo && (t == S + ack_d);
            if (rst_at > 0 && t == S + rst_at) begin
                #2;
                isa_reset_n = 1'b0;
                isa_ior = 1'b1;
                isa_iow = 1'b1;
                reg_ack = 1'b0;
                fill_idle(t);
                #1;
                chk("rst_chrdy_now", isa_chrdy, 1'b1);
                chk("rst_oe_now", isa_data_oe, 1'b0);
                chk("rst_rdstb_now", reg_rd_stb, 1'b0);
                wait_edges(2);
                isa_reset_n = 1'b1;
                isa_aen = 1'b0;
                return;
            end
            wait_edges(1);
        end
        reg_ack     = 1'b0;
        isa_aen     = 1'b0;
        isa_data_in = ~wd;
    endtask

    task automatic both_fall(input logic [9:0] a);
        isa_addr = a;
        isa_ale  = 1'b1;
        wait_edges(1);
        isa_ale = 1'b0;
        clr_mon();
        isa_ior = 1'b0;
        isa_iow = 1'b0;
        wait_edges(6);
        isa_ior = 1'b1;
        isa_iow = 1'b1;
        wait_edges(5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fill_idle(0);
        isa_reset_n = 1'b1;
        isa_addr = '0; isa_ale = 1'b0; isa_aen = 1'b0;
        isa_ior = 1'b1; isa_iow = 1'b1; isa_data_in = '0;
        reg_rd_data = '0; reg_ack = 1'b0;
        clr_mon();
        last_e = 0;
        #1 isa_reset_n = 1'b0;
        #1;
        chk("reset_chrdy", isa_chrdy, 1'b1);
        chk("reset_oe", isa_data_oe, 1'b0);
        chk("reset_sd", isa_data_out, 8'h00);
        chk("reset_addr", reg_addr, 2'd0);
        chk("reset_wd", reg_wr_data, 8'h00);
        wait_edges(2);
        isa_reset_n = 1'b1;
        wait_edges(2);

        // T1 read hit at 0x113, ack 3 clocks after strobe
        do_cycle(1'b0, 10'h113, 1'b0, 8'h00, 3, 8'h5A, 10, 0);
        chk("t1_low", mon_low, 4);
        chk("t1_rdstb", mon_rs, 1);
        chk("t1_latency", mon_first - last_e, 3);
        chk("t1_sd", mon_sd, 8'h5A);
        chk("t1_oe_len", mon_oe, 6);
        chk("t1_addr", reg_addr, 2'd3);

        // T2 write hit at 0x111
        do_cycle(1'b1, 10'h111, 1'b0, 8'hC3, 1, 8'h00, 6, 0);
        chk("t2_low", mon_low, 2);
        chk("t2_wrstb", mon_ws, 1);
        chk("t2_oe", mon_oe, 0);
        chk("t2_addr", reg_addr, 2'd1);
        chk("t2_wdata", reg_wr_data, 8'hC3);

        // T3 miss by address, then by AEN
        do_cycle(1'b0, 10'h213, 1'b0, 8'h00, 3, 8'h11, 8, 0);
        chk("t3a_low", mon_low, 0);
        chk("t3a_rdstb", mon_rs, 0);
        do_cycle(1'b0, 10'h113, 1'b1, 8'h00, 3, 8'h11, 8, 0);
        chk("t3b_low", mon_low, 0);
        chk("t3b_oe", mon_oe, 0);

        // T4 timeout read at 0x110
        do_cycle(1'b0, 10'h110, 1'b0, 8'h00, 0, 8'h77, 16, 0);
        chk("t4_low", mon_low, W);
        chk("t4_timeout", mon_to, 1);
        chk("t4_sd", mon_sd, 8'hFF);
        chk("t4_oe_len", mon_oe, 8);

        // T5 ack on the last wait cycle
        do_cycle(1'b0, 10'h112, 1'b0, 8'h00, W - 1, 8'h3C, 14, 0);
        chk("t5_low", mon_low, W);
        chk("t5_timeout", mon_to, 0);
        chk("t5_sd", mon_sd, 8'h3C);

        // T6 simultaneous strobes ignored; reset in WAIT_ACK; recovery read
        both_fall(10'h111);
        chk("t6_low", mon_low, 0);
        chk("t6_stb", mon_rs + mon_ws, 0);
        do_cycle(1'b0, 10'h113, 1'b0, 8'h00, 0, 8'h00, 20, 2);
        wait_edges(3);
        do_cycle(1'b0, 10'h113, 1'b0, 8'h00, 2, 8'hA5, 8, 0);
        chk("t6_low_after", mon_low, 3);
        chk("t6_rdstb_after", mon_rs, 1);
        chk("t6_sd_after", mon_sd, 8'hA5);

        wait_edges(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
